act_requant: RTL and testbench



---
 rtl/act_requant.sv | 146 ++++++++++++++
 tb/tb_act_requant.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/act_requant.sv
// act_requant: buffers one vector of signed accumulator sums, derives a
// power-of-two scale from the vector's absolute maximum, then drains the
// vector as rounded, saturated signed activations.
module act_requant #(
  parameter int VEC_LEN = 16,
  parameter int IN_W    = 20,
  parameter int OUT_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last,
  output logic [3:0]              out_shift
);

  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int BL_W  = $clog2(IN_W + 1);
  // Magnitude bits available in a signed activation (7 for OUT_W = 8).
  localparam int MAG_W = OUT_W - 1;

  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic signed [IN_W:0] SAT_MAX  = (IN_W + 1)'((1 << MAG_W) - 1);
  localparam logic signed [IN_W:0] SAT_MIN  = -SAT_MAX;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_SCALE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [IDX_W-1:0]       idx;
  logic [IN_W-1:0]        absmax;
  logic [3:0]             shift;
  logic signed [IN_W-1:0] mem [VEC_LEN];

  logic                   fill_hs;
  logic                   drain_hs;
  logic                   at_last;
  logic [IN_W-1:0]        abs_in;
  logic [BL_W-1:0]        bitlen;
  logic [3:0]             shift_calc;
  logic signed [IN_W-1:0] x;
  logic signed [IN_W:0]   x_ext;
  logic signed [IN_W:0]   half;
  logic signed [IN_W:0]   rounded;
  logic signed [IN_W:0]   clamped;

  assign fill_hs  = in_valid & in_ready;
  assign drain_hs = out_valid & out_ready;
  assign at_last  = (idx == LAST_IDX);

  // Magnitude in IN_W unsigned bits: the most negative input maps to 2^(IN_W-1).
  assign abs_in = in_data[IN_W-1] ? $unsigned(-in_data) : $unsigned(in_data);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FILL;
    else        state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && at_last) state_next = S_SCALE;
      end
      S_SCALE: state_next = S_DRAIN;
      S_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && at_last) state_next = S_FILL;
      end
      default: state_next = S_FILL;
    endcase
  end

  // Index, running absolute maximum and the registered shift.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      idx    <= '0;
      absmax <= '0;
      shift  <= '0;
    end else begin
      case (state)
        S_FILL: if (fill_hs) begin
          idx <= at_last ? '0 : idx + IDX_W'(1);
          if (abs_in > absmax) absmax <= abs_in;
        end
        S_SCALE: shift <= shift_calc;
        S_DRAIN: if (drain_hs) begin
          if (at_last) begin
            idx    <= '0;
            absmax <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Vector storage, written during fill.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; the index and state reset, so stale contents are never drained.
    if (state == S_FILL && fill_hs) mem[idx] <= in_data;
  end

  // Shift choice: smallest s with absmax >> s fitting in MAG_W bits.
  always_comb begin
    bitlen = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (absmax[i]) bitlen = BL_W'(i + 1);
    end
    shift_calc = '0;
    if (bitlen > BL_W'(MAG_W)) shift_calc = 4'(bitlen - BL_W'(MAG_W));
  end

  // Round half toward +inf, arithmetic shift, then symmetric saturation.
  always_comb begin
    x       = mem[idx];
    x_ext   = {x[IN_W-1], x};
    half    = '0;
    if (shift != 4'd0) half = (IN_W + 1)'(1) <<< (shift - 4'd1);
    rounded = (x_ext + half) >>> shift;
    clamped = rounded;
    if (rounded > SAT_MAX) clamped = SAT_MAX;
    if (rounded < SAT_MIN) clamped = SAT_MIN;
  end

  assign out_data  = out_valid ? OUT_W'(clamped) : '0;
  assign out_last  = out_valid & at_last;
  assign out_shift = out_valid ? shift : 4'd0;

endmodule

// File: tb/tb_act_requant.sv
// Testbench for act_requant with VEC_LEN = 4: table-driven vectors, random
// vectors against a behavioural model, backpressure and mid-drain reset.
module tb_act_requant;

  localparam int N = 4;

  typedef int vec_t[N];
  typedef struct {
    vec_t din;
    vec_t dout;
    int   s;
  } case_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [19:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic              out_last;
  logic [3:0]        out_shift;

  int tests = 0;
  int fails = 0;

  act_requant #(.VEC_LEN(N), .IN_W(20), .OUT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_shift (out_shift)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: scale is the smallest s with absmax/2^s <= 127; each element
  // is floor((x + 2^(s-1)) / 2^s) clamped to +-127.
  function automatic void model(input vec_t v, output vec_t o, output int s);
    int     a = 0;
    longint t;
    for (int i = 0; i < N; i++) begin
      int m = (v[i] < 0) ? -v[i] : v[i];
      if (m > a) a = m;
    end
    s = 0;
    while ((a >> s) > 127) s++;
    for (int i = 0; i < N; i++) begin
      if (s == 0) t = longint'(v[i]);
      else        t = (longint'(v[i]) + (longint'(1) << (s - 1))) >>> s;
      if (t > 127)  t = 127;
      if (t < -127) t = -127;
      o[i] = int'(t);
    end
  endfunction

  // Feed one vector; returns at the negedge after the final acceptance.
  task automatic send_vec(input vec_t v, input bit hold);
    for (int i = 0; i < N; i++) begin
      int budget = 50;
      in_valid = 1'b1;
      in_data  = 20'(v[i]);
      while (!in_ready && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (!in_ready) check("send_timeout", 0, 1);
      @(negedge clk);
    end
    if (!hold) in_valid = 1'b0;
  endtask

  // Drain up to n elements with optional random 1-3 cycle stalls.
  task automatic recv_vec(input vec_t exp, input int s, input bit stall, input int n);
    int  got = 0;
    int  stall_left = 0;
    int  budget = 200;
    bit  held = 1'b0;
    int  h_data = 0, h_shift = 0, h_last = 0;
    bit  done = 1'b0;
    while (!done && budget > 0) begin
      budget--;
      if (held) begin
        check("stall_data_stable", int'(out_data), h_data);
        check("stall_shift_stable", int'(out_shift), h_shift);
        check("stall_last_stable", int'(out_last), h_last);
        held = 1'b0;
      end
      if (stall && stall_left == 0 && ($urandom % 3 == 0)) stall_left = $urandom_range(1, 3);
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (out_valid) begin
        check("drain_in_ready_low", int'(in_ready), 0);
        if (out_ready) begin
          check("out_data", int'(out_data), exp[got]);
          check("out_shift", int'(out_shift), s);
          check("out_last", int'(out_last), (got == N - 1) ? 1 : 0);
          if (out_data == -8'sd128) check("never_minus_128", int'(out_data), -127);
          got++;
          if (got == n) done = 1'b1;
        end else begin
          held    = 1'b1;
          h_data  = int'(out_data);
          h_shift = int'(out_shift);
          h_last  = int'(out_last);
        end
      end
      @(negedge clk);
    end
    if (!done) check("recv_timeout", got, n);
    out_ready = 1'b0;
    if (n == N) begin
      check("post_last_in_ready", int'(in_ready), 1);
      check("post_last_out_valid", int'(out_valid), 0);
      check("post_last_out_data", int'(out_data), 0);
      in_valid = 1'b0;
    end
  endtask

  // Full vector: send, check scale-cycle latency, drain.
  task automatic run_vec(input vec_t din, input vec_t exp, input int s, input bit stall);
    send_vec(din, stall);
    check("scale_out_valid_low", int'(out_valid), 0);
    check("scale_in_ready_low", int'(in_ready), 0);
    @(negedge clk);
    check("latency_out_valid", int'(out_valid), 1);
    recv_vec(exp, s, stall, N);
  endtask

  case_t tbl[6];
  vec_t  rv, re;
  int    rs;

  initial begin
    tbl[0] = '{din: '{5, -7, 127, 0},             dout: '{5, -7, 127, 0},    s: 0};
    tbl[1] = '{din: '{255, 201, -201, -3},        dout: '{127, 101, -100, -1}, s: 1};
    tbl[2] = '{din: '{-524288, 524287, 4096, -4095}, dout: '{-64, 64, 1, 0},  s: 13};
    tbl[3] = '{din: '{0, 0, 0, 0},                dout: '{0, 0, 0, 0},       s: 0};
    tbl[4] = '{din: '{128, 0, 0, 0},              dout: '{64, 0, 0, 0},      s: 1};
    tbl[5] = '{din: '{-128, 127, -1, 1},          dout: '{-64, 64, 0, 1},    s: 1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset and idle.
    repeat (3) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_out_last", int'(out_last), 0);
    check("reset_out_shift", int'(out_shift), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_in_ready", int'(in_ready), 1);
      check("idle_out_valid", int'(out_valid), 0);
      check("idle_out_data", int'(out_data), 0);
    end

    // Table vectors, consumer always ready.
    for (int i = 0; i < 6; i++) run_vec(tbl[i].din, tbl[i].dout, tbl[i].s, 1'b0);

    // Table vectors again with backpressure and in_valid held high.
    for (int i = 0; i < 3; i++) run_vec(tbl[i].din, tbl[i].dout, tbl[i].s, 1'b1);

    // Random vectors against the model.
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < N; i++) begin
        int m = $urandom_range(0, 19);
        rv[i] = int'($urandom_range(0, (1 << m) - 1));
        if ($urandom % 2 == 1) rv[i] = -rv[i];
        if ($urandom % 16 == 0) rv[i] = -524288;
      end
      model(rv, re, rs);
      run_vec(rv, re, rs, k[0]);
    end

    // Reset mid-drain after two of four outputs.
    rv = '{100000, -90000, 5000, 7};
    model(rv, re, rs);
    send_vec(rv, 1'b0);
    @(negedge clk);
    recv_vec(re, rs, 1'b0, 2);
    rst_n = 1'b0;
    #1;
    check("mid_reset_in_ready", int'(in_ready), 1);
    check("mid_reset_out_valid", int'(out_valid), 0);
    check("mid_reset_out_data", int'(out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rv = '{1, 2, 3, 4};
    run_vec(rv, rv, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
